// File: rtl/shared_cla_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// shared_cla_sequencer_pkg: slice width, FSM encoding and arbitration helper
// Revision: 1.0
// ============================================================================
package shared_cla_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Returns {grant1, grant0}; on a tie the requester other than last_id wins.
  function automatic logic [1:0] rr_grant(input logic v0, input logic v1, input logic last_id);
    logic [1:0] g;
    g[0] = v0 & (~v1 | last_id);
    g[1] = v1 & (~v0 | ~last_id);
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_cla_sequencer_cla4_slice.sv
`default_nettype none
// ============================================================================
// shared_cla_sequencer_cla4_slice: 4-bit carry-look-ahead adder slice
// Revision: 1.0
// ============================================================================
module shared_cla_sequencer_cla4_slice
  import shared_cla_sequencer_pkg::*;
(
  input  logic [SLICE_W-1:0] x_i,
  input  logic [SLICE_W-1:0] y_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               cout_o
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  assign w_p = x_i ^ y_i;
  assign w_g = x_i & y_i;

  assign w_c[0] = cin_i;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign s_o    = w_p ^ w_c[3:0];
  assign cout_o = w_c[4];

endmodule
`default_nettype wire

// File: rtl/shared_cla_sequencer.sv
`default_nettype none
// ============================================================================
// shared_cla_sequencer: two requesters share one CLA slice, WIDTH-bit add LSB first
// Revision: 1.0
// ============================================================================
module shared_cla_sequencer
  import shared_cla_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req0_cin_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic             req1_cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_id_o,
  output logic             busy_o
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NSLICE - 1);

  state_e             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic               id_q, id_d;

  logic [1:0]         w_grant;
  logic [SLICE_W-1:0] w_x;
  logic [SLICE_W-1:0] w_y;
  logic [SLICE_W-1:0] w_s;
  logic               w_cout;

  assign w_grant = rr_grant(req0_valid_i, req1_valid_i, rr_last_q);

  assign w_x = a_q[k_q*SLICE_W +: SLICE_W];
  assign w_y = b_q[k_q*SLICE_W +: SLICE_W];

  shared_cla_sequencer_cla4_slice u_slice (
    .x_i    (w_x),
    .y_i    (w_y),
    .cin_i  (carry_q),
    .s_o    (w_s),
    .cout_o (w_cout)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      k_q       <= '0;
      id_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      k_q       <= k_d;
      id_q      <= id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    carry_d      = carry_q;
    k_d          = k_q;
    id_d         = id_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    out_valid_o  = 1'b0;
    busy_o       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        busy_o       = 1'b0;
        req0_ready_o = w_grant[0];
        req1_ready_o = w_grant[1];
        if (w_grant[0] | w_grant[1]) begin
          a_d       = w_grant[1] ? req1_a_i   : req0_a_i;
          b_d       = w_grant[1] ? req1_b_i   : req0_b_i;
          carry_d   = w_grant[1] ? req1_cin_i : req0_cin_i;
          id_d      = w_grant[1];
          rr_last_d = w_grant[1];
          k_d       = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry out of the top slice is simply not consumed: the sum wraps.
        sum_d[k_q*SLICE_W +: SLICE_W] = w_s;
        carry_d = w_cout;
        k_d     = k_q + CNT_W'(1);
        if (k_q == LAST_K) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign out_sum_o = sum_q;
  assign out_id_o  = id_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_cla_sequencer.sv
`default_nettype none
// ============================================================================
// tb_shared_cla_sequencer: scoreboard bench with directed and random traffic
// Revision: 1.0
// ============================================================================
module tb_shared_cla_sequencer;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk;
  logic         reset_i;
  logic         req0_valid_i, req0_ready_o, req0_cin_i;
  logic [W-1:0] req0_a_i, req0_b_i;
  logic         req1_valid_i, req1_ready_o, req1_cin_i;
  logic [W-1:0] req1_a_i, req1_b_i;
  logic         out_valid_o, out_ready_i, out_id_o, busy_o;
  logic [W-1:0] out_sum_o;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int rdy_mode = 0;

  logic [W-1:0] exp_sum_q[$];
  logic         exp_id_q[$];
  int           acc_cyc_q[$];
  int           id_log[$];

  logic         model_last = 1'b1;
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_id;
  logic [W-1:0] last_sum;
  logic         last_id;
  logic         m_e0, m_e1;

  shared_cla_sequencer #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req0_cin_i   (req0_cin_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req1_cin_i   (req1_cin_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_sum_o    (out_sum_o),
    .out_id_o     (out_id_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    return a + b + W'(c);
  endfunction

  // Consumer ready: 0 = always ready, 1 = random stalls, 2 = always stalled
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ($urandom_range(0, 2) != 0);
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: arbitration model, expected-result push on accept, compare on output
  always @(negedge clk) begin
    if (reset_i) begin
      exp_sum_q.delete();
      exp_id_q.delete();
      acc_cyc_q.delete();
      model_last = 1'b1;
      prev_valid = 1'b0;
    end else begin
      m_e0 = 1'b0;
      m_e1 = 1'b0;
      if (!busy_o) begin
        m_e0 = req0_valid_i && (!req1_valid_i || model_last);
        m_e1 = req1_valid_i && (!req0_valid_i || !model_last);
      end
      chk("ready", W'({req1_ready_o, req0_ready_o}), W'({m_e1, m_e0}));
      if (req0_valid_i && req0_ready_o) begin
        exp_sum_q.push_back(ref_add(req0_a_i, req0_b_i, req0_cin_i));
        exp_id_q.push_back(1'b0);
        acc_cyc_q.push_back(cycle + 1);
        model_last = 1'b0;
      end else if (req1_valid_i && req1_ready_o) begin
        exp_sum_q.push_back(ref_add(req1_a_i, req1_b_i, req1_cin_i));
        exp_id_q.push_back(1'b1);
        acc_cyc_q.push_back(cycle + 1);
        model_last = 1'b1;
      end
      if (out_valid_o) begin
        if (exp_sum_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got sum %h with no outstanding request", out_sum_o);
        end else begin
          if (!prev_valid) chk("latency", W'(cycle - acc_cyc_q[0]), W'(NS));
          else begin
            chk("stable_sum", out_sum_o, prev_sum);
            chk("stable_id", W'(out_id_o), W'(prev_id));
          end
          if (out_ready_i) begin
            chk("sum", out_sum_o, exp_sum_q.pop_front());
            chk("id", W'(out_id_o), W'(exp_id_q.pop_front()));
            void'(acc_cyc_q.pop_front());
            id_log.push_back(int'(out_id_o));
            last_sum = out_sum_o;
            last_id  = out_id_o;
          end
        end
      end
      prev_valid = out_valid_o && !out_ready_i;
      prev_sum   = out_sum_o;
      prev_id    = out_id_o;
    end
  end

  task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int  t = 0;
    bit  done = 0;
    @(posedge clk);
    #1;
    if (r == 0) begin
      req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; req0_cin_i = c;
    end else begin
      req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; req1_cin_i = c;
    end
    while (!done) begin
      @(negedge clk);
      if ((r == 0) ? req0_ready_o : req1_ready_o) done = 1;
      else if (++t > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: requester %0d got no ready, expected ready within 300", r);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    // Scramble the operands after acceptance; the DUT must ignore them.
    if (r == 0) begin
      req0_valid_i = 1'b0; req0_a_i = W'($urandom); req0_b_i = W'($urandom);
      req0_cin_i = 1'($urandom);
    end else begin
      req1_valid_i = 1'b0; req1_a_i = W'($urandom); req1_b_i = W'($urandom);
      req1_cin_i = 1'($urandom);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_sum_q.size() != 0 || busy_o) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", exp_sum_q.size());
    end
  endtask

  task automatic rand_stream(input int r, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(r, W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    int t;
    reset_i = 1'b1;
    req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0; req0_cin_i = 1'b0;
    req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0; req1_cin_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid_o), '0);
    chk("rst_out_sum", out_sum_o, '0);
    chk("rst_out_id", W'(out_id_o), '0);
    chk("rst_busy", W'(busy_o), '0);

    send(0, 16'h1234, 16'h4321, 1'b0); drain();
    chk("t1_sum", last_sum, 16'h5555);
    chk("t1_id", W'(last_id), '0);
    send(1, 16'h0FFF, 16'h0001, 1'b0); drain();
    chk("t2_sum", last_sum, 16'h1000);
    chk("t2_id", W'(last_id), W'(1));
    send(0, 16'hFFFF, 16'h0001, 1'b0); drain();
    chk("t3a_sum", last_sum, 16'h0000);
    send(1, 16'hFFFF, 16'h0000, 1'b1); drain();
    chk("t3b_sum", last_sum, 16'h0000);

    id_log.delete();
    fork
      begin send(0, 16'h0101, 16'h1010, 1'b1); send(0, 16'h8000, 16'h8000, 1'b0); end
      begin send(1, 16'h7FFF, 16'h0001, 1'b0); send(1, 16'hABCD, 16'h1111, 1'b1); end
    join
    drain();
    chk("t4_count", W'(id_log.size()), W'(4));
    for (int i = 0; i < 4 && i < id_log.size(); i++) chk("t4_order", W'(id_log[i]), W'(i % 2));

    rdy_mode = 2;
    send(0, W'($urandom), W'($urandom), 1'($urandom));
    t = 0;
    while (!out_valid_o && t < 50) begin @(negedge clk); t++; end
    chk("t5_reached_done", W'(out_valid_o), W'(1));
    @(posedge clk);
    #1;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_still_valid", W'(out_valid_o), W'(1));
    @(posedge clk);
    rdy_mode = 0;
    #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    drain();

    send(1, W'($urandom), W'($urandom), 1'($urandom));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", W'(out_valid_o), '0);
    chk("t6_busy", W'(busy_o), '0);
    id_log.delete();
    fork
      send(0, 16'h0F0F, 16'h00F1, 1'b0);
      send(1, 16'h2222, 16'h3333, 1'b1);
    join
    drain();
    chk("t6_first_grant", W'(id_log.size() > 0 ? id_log[0] : 9), '0);

    rdy_mode = 1;
    fork
      rand_stream(0, 40);
      rand_stream(1, 40);
    join
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
